// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Optional feature macro used by this slice: PIPE_PERF_CNT_EN.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  // Run mode of the core; the encoding is visible on the mode output.
  typedef enum logic [1:0] {
    STALL = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    STOP  = 2'd3
  } mode_t;

  // Per-stage pipeline register update codes.
  localparam logic [1:0] UPD_HOLD = 2'b00;
  localparam logic [1:0] UPD_ADV  = 2'b01;
  localparam logic [1:0] UPD_CLR  = 2'b10;
  localparam logic [1:0] UPD_BUB  = 2'b11;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline sequencer and the surrounding core.
// Optional feature macro: PIPE_PERF_CNT_EN adds the performance counters.
//
// Handshake semantics: aa_recieved, load_done and aa_sent are level-sampled
// qualifiers with no back-pressure; the sequencer acts on the clock edge at
// which they are high in the mode that listens for them (aa_recieved in
// STALL, load_done together with aa_sent in LOAD). The core-side inputs
// (stop, busy, jump, branch_taken, hazard) are likewise sampled every EXEC
// cycle, and upd/pc/exec_start are the sequencer's answer for that cycle.
`timescale 1ns/1ps
interface pipe_ctrl_if #(
  parameter int NSTAGE = 3,
  parameter int LAT_W  = 5,
  parameter int PC_W   = 32
);
  logic                  aa_recieved;
  logic                  load_done;
  logic                  aa_sent;
  logic                  stop;
  logic [LAT_W-1:0]      wait_time;
  logic                  busy;
  logic                  jump;
  logic [PC_W-1:0]       jump_target;
  logic                  branch_taken;
  logic [PC_W-1:0]       branch_target;
  logic                  hazard;
  logic [1:0]            mode;
  logic [PC_W-1:0]       pc;
  logic [2*NSTAGE-1:0]   upd;
  logic                  exec_start;
  logic [LAT_W-1:0]      latency;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]           cyc_cnt;
  logic [31:0]           ret_cnt;
  logic [31:0]           stall_cnt;
`endif

  // Core side: drives requests, observes the sequencer.
  modport master (
    output aa_recieved, load_done, aa_sent, stop, wait_time, busy,
           jump, jump_target, branch_taken, branch_target, hazard,
    input  mode, pc, upd, exec_start, latency
`ifdef PIPE_PERF_CNT_EN
   ,input  cyc_cnt, ret_cnt, stall_cnt
`endif
  );

  // Sequencer side.
  modport slave (
    input  aa_recieved, load_done, aa_sent, stop, wait_time, busy,
           jump, jump_target, branch_taken, branch_target, hazard,
    output mode, pc, upd, exec_start, latency
`ifdef PIPE_PERF_CNT_EN
   ,output cyc_cnt, ret_cnt, stall_cnt
`endif
  );

endinterface

// File: rtl/pipe_lat_cnt.sv
// Multi-cycle latency counter: clear has priority, increment saturates.
`timescale 1ns/1ps
module pipe_lat_cnt #(
  parameter int LAT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [LAT_W-1:0] cnt_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != {LAT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: run-mode FSM, fetch PC, latency tracking and the
// per-stage update codes, with branch-redirect flush and load-use bubbles.
// Optional feature macro: PIPE_PERF_CNT_EN (cycle/retire/stall counters).
`timescale 1ns/1ps
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              NSTAGE      = 3,
  parameter int              LAT_W       = 5,
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              HZ_SPLIT    = 1,
  parameter int              FLUSH_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rstn,
  pipe_ctrl_if.slave bus
);

  mode_t               mode_q;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     pc_d;
  logic                exec_start_q;
  logic [2*NSTAGE-1:0] upd_d;
  logic [LAT_W-1:0]    lat;
  logic                in_exec;
  logic                jstall;
  logic                adv;
  logic                redir;
  logic                hz;
  logic                lat_inc;

  // Cycle qualifiers; all are zero outside EXEC so nothing moves there.
  always_comb begin
    in_exec = (mode_q == EXEC);
    jstall  = in_exec && bus.jump && (lat == '0);
    adv     = in_exec && (lat >= bus.wait_time) && !bus.busy && !jstall;
    redir   = adv && bus.branch_taken;
    hz      = adv && bus.hazard && !redir;
    lat_inc = in_exec && ((lat < bus.wait_time) || jstall);
  end

  pipe_lat_cnt #(.LAT_W(LAT_W)) u_lat (
    .clk     (clk),
    .rstn    (rstn),
    .clear_i (adv),
    .inc_i   (lat_inc),
    .cnt_o   (lat)
  );

  // Next fetch PC: redirect beats jump, sequential fetch only on a clean advance.
  always_comb begin
    pc_d = pc_q;
    if (redir)
      pc_d = bus.branch_target;
    else if (jstall)
      pc_d = bus.jump_target;
    else if (adv && !hz && !bus.jump)
      pc_d = pc_q + PC_W'(4);
  end

  // Per-stage update codes; stage i occupies upd[2i+1:2i].
  always_comb begin
    logic [1:0] code;
    upd_d = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      code = UPD_ADV;
      if (!in_exec)
        code = UPD_CLR;
      else if (!adv)
        code = UPD_HOLD;
      else if (redir)
        code = (i < FLUSH_DEPTH) ? UPD_BUB : UPD_ADV;
      else if (hz) begin
        if (i < HZ_SPLIT)       code = UPD_HOLD;
        else if (i == HZ_SPLIT) code = UPD_BUB;
        else                    code = UPD_ADV;
      end
      upd_d[2*i +: 2] = code;
    end
  end

  // Mode FSM with registered PC and exec_start pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q       <= STALL;
      pc_q         <= RESET_PC;
      exec_start_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      exec_start_q <= adv;
      case (mode_q)
        STALL:   if (bus.aa_recieved)               mode_q <= LOAD;
        LOAD:    if (bus.load_done && bus.aa_sent)  mode_q <= EXEC;
        EXEC:    if (bus.stop)                      mode_q <= STOP;
        STOP:                                       mode_q <= STOP;
        default:                                    mode_q <= STALL;
      endcase
    end
  end

  assign bus.mode       = mode_q;
  assign bus.pc         = pc_q;
  assign bus.upd        = upd_d;
  assign bus.exec_start = exec_start_q;
  assign bus.latency    = lat;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] ret_cnt_q;
  logic [31:0] stall_cnt_q;

  // Performance counters; they only count in EXEC so they freeze in STOP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt_q   <= '0;
      ret_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (in_exec)          cyc_cnt_q   <= cyc_cnt_q + 32'd1;
      if (adv && !hz)       ret_cnt_q   <= ret_cnt_q + 32'd1;
      if (in_exec && !adv)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.cyc_cnt   = cyc_cnt_q;
  assign bus.ret_cnt   = ret_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with an expected-value queue and a monitor.
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam int NSTAGE = 3;
  localparam int LAT_W  = 5;
  localparam int PC_W   = 32;
  localparam int W      = 2 + PC_W + 2*NSTAGE + 1 + LAT_W;

  logic clk;
  logic rstn;

  pipe_ctrl_if #(.NSTAGE(NSTAGE), .LAT_W(LAT_W), .PC_W(PC_W)) bus ();

  pipe_ctrl #(
    .NSTAGE(NSTAGE), .LAT_W(LAT_W), .PC_W(PC_W), .RESET_PC(32'h0),
    .HZ_SPLIT(1), .FLUSH_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  function automatic logic [W-1:0] pack(input logic [1:0] m, input logic [PC_W-1:0] p,
                                        input logic [2*NSTAGE-1:0] u, input logic e,
                                        input logic [LAT_W-1:0] l);
    return {m, p, u, e, l};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.aa_recieved   = 1'b0;
    bus.load_done     = 1'b0;
    bus.aa_sent       = 1'b0;
    bus.stop          = 1'b0;
    bus.wait_time     = '0;
    bus.busy          = 1'b0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.hazard        = 1'b0;
  endtask

  // Inputs for this cycle are already applied; record what the outputs
  // must show during this cycle, then move to just after the next edge.
  task automatic step(input string nm, input logic [1:0] m, input logic [PC_W-1:0] p,
                      input logic [2*NSTAGE-1:0] u, input logic e, input logic [LAT_W-1:0] l);
    exp_q.push_back(pack(m, p, u, e, l));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act   = pack(bus.mode, bus.pc, bus.upd, bus.exec_start, bus.latency);
        n_tests++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL %s: got mode=%0d pc=%h upd=%b es=%b lat=%0d, want mode=%0d pc=%h upd=%b es=%b lat=%0d",
                   nm, act[W-1 -: 2], act[W-3 -: PC_W], act[2*NSTAGE+LAT_W -: 2*NSTAGE],
                   act[LAT_W], act[LAT_W-1:0],
                   exp_v[W-1 -: 2], exp_v[W-3 -: PC_W], exp_v[2*NSTAGE+LAT_W -: 2*NSTAGE],
                   exp_v[LAT_W], exp_v[LAT_W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    step("rst_hold",  2'd0, 32'h0, 6'b101010, 1'b0, 5'd0);
    rstn = 1'b1;
    step("rst_idle",  2'd0, 32'h0, 6'b101010, 1'b0, 5'd0);
    bus.aa_recieved = 1'b1;
    step("stall_aa",  2'd0, 32'h0, 6'b101010, 1'b0, 5'd0);
    bus.aa_recieved = 1'b0; bus.load_done = 1'b1; bus.aa_sent = 1'b1;
    step("load",      2'd1, 32'h0, 6'b101010, 1'b0, 5'd0);
    bus.load_done = 1'b0; bus.aa_sent = 1'b0; bus.wait_time = 5'd0;

    // Zero-latency instructions advance every cycle.
    step("run0", 2'd2, 32'd0,  6'b010101, 1'b0, 5'd0);
    step("run1", 2'd2, 32'd4,  6'b010101, 1'b1, 5'd0);
    step("run2", 2'd2, 32'd8,  6'b010101, 1'b1, 5'd0);
    step("run3", 2'd2, 32'd12, 6'b010101, 1'b1, 5'd0);
    step("run4", 2'd2, 32'd16, 6'b010101, 1'b1, 5'd0);

    // Three-cycle instruction.
    bus.wait_time = 5'd3;
    step("wait0", 2'd2, 32'd20, 6'b000000, 1'b1, 5'd0);
    step("wait1", 2'd2, 32'd20, 6'b000000, 1'b0, 5'd1);
    step("wait2", 2'd2, 32'd20, 6'b000000, 1'b0, 5'd2);
    step("wait3", 2'd2, 32'd20, 6'b010101, 1'b0, 5'd3);

    // busy drops exactly as latency reaches wait_time.
    bus.wait_time = 5'd2; bus.busy = 1'b1;
    step("busy0",    2'd2, 32'd24, 6'b000000, 1'b1, 5'd0);
    step("busy1",    2'd2, 32'd24, 6'b000000, 1'b0, 5'd1);
    bus.busy = 1'b0;
    step("busy_rel", 2'd2, 32'd24, 6'b010101, 1'b0, 5'd2);

    // Jump: stall one cycle loading the target, then advance without pc+4.
    bus.jump = 1'b1; bus.jump_target = 32'h40; bus.wait_time = 5'd1;
    step("jstall",   2'd2, 32'd28,  6'b000000, 1'b1, 5'd0);
    step("jump_adv", 2'd2, 32'h40,  6'b010101, 1'b0, 5'd1);

    // Branch and hazard together: redirect wins.
    bus.jump = 1'b0; bus.wait_time = 5'd0;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h80; bus.hazard = 1'b1;
    step("redir_hz", 2'd2, 32'h40, 6'b011111, 1'b1, 5'd0);
    bus.branch_taken = 1'b0;
    step("hazard",   2'd2, 32'h80, 6'b011100, 1'b1, 5'd0);

    // Stop: the stop cycle still advances the PC.
    bus.hazard = 1'b0; bus.stop = 1'b1;
    step("stop_cyc", 2'd2, 32'h80, 6'b010101, 1'b1, 5'd0);
    bus.stop = 1'b0;
    step("stopped0", 2'd3, 32'h84, 6'b101010, 1'b1, 5'd0);
    step("stopped1", 2'd3, 32'h84, 6'b101010, 1'b0, 5'd0);

    // Reset out of STOP, re-enter EXEC, then reset asynchronously mid-run.
    rstn = 1'b0;
    step("rst_stop",  2'd0, 32'h0, 6'b101010, 1'b0, 5'd0);
    rstn = 1'b1;
    step("rst2_idle", 2'd0, 32'h0, 6'b101010, 1'b0, 5'd0);
    bus.aa_recieved = 1'b1;
    step("stall_aa2", 2'd0, 32'h0, 6'b101010, 1'b0, 5'd0);
    bus.aa_recieved = 1'b0; bus.load_done = 1'b1; bus.aa_sent = 1'b1;
    step("load2",     2'd1, 32'h0, 6'b101010, 1'b0, 5'd0);
    bus.load_done = 1'b0; bus.aa_sent = 1'b0;
    step("rerun0", 2'd2, 32'd0, 6'b010101, 1'b0, 5'd0);
    step("rerun1", 2'd2, 32'd4, 6'b010101, 1'b1, 5'd0);
    step("rerun2", 2'd2, 32'd8, 6'b010101, 1'b1, 5'd0);
    rstn = 1'b0;
    step("rst_async", 2'd0, 32'h0, 6'b101010, 1'b0, 5'd0);
    rstn = 1'b1;
    step("rst_final", 2'd0, 32'h0, 6'b101010, 1'b0, 5'd0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending checks, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline sequencer for the CPU core: owns the run mode (STALL/LOAD/EXEC/STOP), the fetch PC, the multi-cycle latency counter and the per-stage pipeline-register update codes. It generalises the fixed 3-register controller to N stages. It adds branch-redirect flush and load-use hazard bubble insertion. It sits beside fetch/decode/execute and drives every stage register's update input.

Parameters:
NSTAGE, 3, number of pipeline registers driven (stage 0 = fetch/decode reg)
LAT_W, 5, width of wait_time and latency counter
PC_W, 32, PC width
RESET_PC, 0, PC value after reset
HZ_SPLIT, 1, index of first stage that receives a bubble on hazard (stages below it hold)
FLUSH_DEPTH, 2, number of youngest stages flushed on branch redirect (1..NSTAGE)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
aa_recieved  in  1  host handshake byte received
load_done  in  1  program load complete
aa_sent  in  1  handshake reply sent
stop  in  1  stop instruction in execute stage
wait_time  in  LAT_W  cycles required by instruction in execute
busy  in  1  execute unit busy (UART in flight)
jump  in  1  decoded instruction is an unconditional jump
jump_target  in  PC_W  decode-computed jump target
branch_taken  in  1  execute resolved a taken branch
branch_target  in  PC_W  resolved branch target
hazard  in  1  decode reports load-use hazard
mode  out  2  0 STALL, 1 LOAD, 2 EXEC, 3 STOP
pc  out  PC_W  fetch address
upd  out  2*NSTAGE  per-stage code, stage i at [2i+1:2i]: 00 hold, 01 advance, 10 clear, 11 bubble
exec_start  out  1  registered one-cycle pulse after each advance
latency  out  LAT_W  current latency count

Behaviour:
- Reset (async, rstn=0): mode=STALL, pc=RESET_PC, latency=0, exec_start=0; upd=10 on all stages while mode!=EXEC.
- Mode FSM: STALL->LOAD on aa_recieved; LOAD->EXEC when load_done && aa_sent in the same cycle; EXEC->STOP on stop; STOP terminal until reset.
- In the cycle stop is sampled, all other EXEC updates still take effect.
- Combinational, EXEC only:
  - jstall = jump && latency==0
  - adv = latency>=wait_time && !busy && !jstall
  - redir = adv && branch_taken
  - hz = adv && hazard && !redir
- upd, EXEC:
  - !adv: all 00.
  - redir: stages < FLUSH_DEPTH get 11; the others get 01.
  - hz: stages < HZ_SPLIT get 00; stage HZ_SPLIT gets 11; stages > HZ_SPLIT get 01.
  - Otherwise: all 01.
- upd outside EXEC: all 10.
- pc, EXEC, in priority order:
  - redir: pc<=branch_target.
  - jstall: pc<=jump_target.
  - adv && !hz && !jump: pc<=pc+4, mod 2^PC_W.
  - Otherwise: hold.
- latency:
  - On adv: <=0.
  - Else if latency<wait_time or jstall: <=latency+1, saturating at 2^LAT_W-1.
  - Else: hold.
- exec_start <= adv each cycle in EXEC; 0 outside EXEC.
- Boundary cases:
  - wait_time=0 with no jump advances every cycle.
  - busy deasserting exactly when latency reaches wait_time advances in that cycle.
  - Simultaneous hazard and branch_taken: redirect wins; no bubble is inserted.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: adds outputs cyc_cnt[31:0] (cycles in EXEC), ret_cnt[31:0] (adv cycles without hz), stall_cnt[31:0] (EXEC cycles with !adv).
- All three counters clear on reset and freeze in STOP.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package constant: mode localparams STALL/LOAD/EXEC/STOP, upd code constants UPD_HOLD/UPD_ADV/UPD_CLR/UPD_BUB, typedef mode_t.
- One sub-module, pipe_lat_cnt: the latency counter with saturation, inputs clear/inc.
- FSM, PC and upd generation stay in pipe_ctrl.

Test Plan:
- Reset, then aa_recieved pulse, then load_done=aa_sent=1: mode 0->1->2; upd=101010 until EXEC; pc=0.
- EXEC, wait_time=0, no jump/hazard for 4 cycles: pc 0->4->8->12->16; upd=010101 each cycle; exec_start follows adv one cycle late.
- wait_time=3, busy=0: upd=000000 for 3 cycles, then 010101 once; latency 0,1,2,3,0.
- jump=1, jump_target=0x40 at latency 0: cycle 1 pc<=0x40 and upd all 00; cycle 2 advances with pc unchanged at 0x40.
- branch_taken=1, branch_target=0x80, hazard=1 in the same adv cycle (NSTAGE=3, FLUSH_DEPTH=2): pc<=0x80; upd stage0=11, stage1=11, stage2=01.
- hazard=1 alone (HZ_SPLIT=1): upd stage0=00, stage1=11, stage2=01; pc held. Then stop=1: mode=3 next cycle; upd=101010. Assert rstn=0 mid-EXEC: outputs return to reset values without waiting for a clock edge.
